// File: rtl/addsub_pkg.sv
// Shared constants and configuration helpers for the pipelined adder/subtractor.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Bits handled by each carry segment.
    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

    // Legal configuration: 1..WIDTH stages, WIDTH an exact multiple of STAGES.
    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/addsub_segment.sv
// One carry segment: SEG-bit add of A and (optionally inverted) B with carry-in.
// Also exposes the carry into the segment's top bit for signed-overflow detection.
module addsub_segment #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] i_a,
    input  logic [SEG-1:0] i_b,
    input  logic           i_sub,
    input  logic           i_ci,
    output logic [SEG-1:0] o_s,
    output logic           o_co,
    output logic           o_c_msb
);

    logic [SEG-1:0] w_b;

    // Invert B for subtract; the +1 arrives as carry-in of the lowest segment.
    always_comb begin
        w_b           = i_b ^ {SEG{i_sub}};
        {o_co, o_s}   = {1'b0, i_a} + {1'b0, w_b} + {{SEG{1'b0}}, i_ci};
        // Sum bit = a ^ b ^ carry_in, so the carry into the top bit falls out directly.
        o_c_msb       = o_s[SEG-1] ^ i_a[SEG-1] ^ w_b[SEG-1];
    end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined ripple-segment adder/subtractor with valid/ready handshake and
// status flags. Each of STAGES stages resolves one SEG-bit carry segment.
// Optional signed saturation is enabled by defining ADDSUB_SAT_EN.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_co,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
);

    localparam int SEG  = seg_width(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("addsub_pipe: WIDTH must be a non-zero multiple of STAGES");
    end

    // Per-stage inputs (from the port for stage 0, from the previous register otherwise)
    logic [WIDTH-1:0] w_a     [STAGES];
    logic [WIDTH-1:0] w_b     [STAGES];
    logic [WIDTH-1:0] w_sprev [STAGES];
    logic [WIDTH-1:0] w_sum   [STAGES];
    logic [WIDTH-1:0] w_snext [STAGES];
    logic             w_sub   [STAGES];
    logic             w_ci    [STAGES];
    logic             w_vin   [STAGES];
    logic [SEG-1:0]   w_seg_s [STAGES];
    logic             w_seg_co[STAGES];
    logic             w_seg_cm[STAGES];

    // Stage registers: operands skew forward, lower sum bits ride along
    logic [STAGES-1:0] r_vld;
    logic [WIDTH-1:0]  r_a   [STAGES];
    logic [WIDTH-1:0]  r_b   [STAGES];
    logic [WIDTH-1:0]  r_sum [STAGES];
    logic              r_sub [STAGES];
    logic              r_c   [STAGES];

    logic             r_co;
    logic             r_ovf;
    logic             r_zero;
    logic             r_neg;

    logic             w_adv;
    logic             w_ovf;
    logic [WIDTH-1:0] w_fin;

`ifdef ADDSUB_SAT_EN
    logic             w_sat [STAGES];
    logic             r_sat [STAGES];
`else
    logic             w_unused_sat;
    assign w_unused_sat = in_sat;
`endif

    // Whole pipe moves in lock-step; it only stalls when the output beat is refused.
    assign w_adv    = ~r_vld[LAST] | out_ready;
    assign in_ready = w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_a[k]     = in_a;
            assign w_b[k]     = in_b;
            assign w_sub[k]   = in_sub;
            assign w_ci[k]    = (in_sub == OP_SUB);
            assign w_vin[k]   = in_valid;
            assign w_sprev[k] = '0;
`ifdef ADDSUB_SAT_EN
            assign w_sat[k]   = in_sat;
`endif
        end else begin : g_next
            assign w_a[k]     = r_a[k-1];
            assign w_b[k]     = r_b[k-1];
            assign w_sub[k]   = r_sub[k-1];
            assign w_ci[k]    = r_c[k-1];
            assign w_vin[k]   = r_vld[k-1];
            assign w_sprev[k] = r_sum[k-1];
`ifdef ADDSUB_SAT_EN
            assign w_sat[k]   = r_sat[k-1];
`endif
        end

        addsub_segment #(.SEG(SEG)) u_seg (
            .i_a     (w_a[k][k*SEG +: SEG]),
            .i_b     (w_b[k][k*SEG +: SEG]),
            .i_sub   (w_sub[k]),
            .i_ci    (w_ci[k]),
            .o_s     (w_seg_s[k]),
            .o_co    (w_seg_co[k]),
            .o_c_msb (w_seg_cm[k])
        );

        // Bits above the current segment are still zero, so OR-ing in the new slice is enough.
        assign w_sum[k]   = w_sprev[k] | (WIDTH'(w_seg_s[k]) << (k*SEG));
        assign w_snext[k] = (k == LAST) ? w_fin : w_sum[k];

        // Stage register: shift the beat forward whenever the pipe advances.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld[k] <= 1'b0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
                r_sub[k] <= 1'b0;
                r_c[k]   <= 1'b0;
`ifdef ADDSUB_SAT_EN
                r_sat[k] <= 1'b0;
`endif
            end else if (w_adv) begin
                r_vld[k] <= w_vin[k];
                r_a[k]   <= w_a[k];
                r_b[k]   <= w_b[k];
                r_sum[k] <= w_snext[k];
                r_sub[k] <= w_sub[k];
                r_c[k]   <= w_seg_co[k];
`ifdef ADDSUB_SAT_EN
                r_sat[k] <= w_sat[k];
`endif
            end
        end
    end

    assign w_ovf = w_seg_co[LAST] ^ w_seg_cm[LAST];

    // Final-stage result; a positive overflow wraps to a negative raw sign and vice versa.
    always_comb begin
        w_fin = w_sum[LAST];
`ifdef ADDSUB_SAT_EN
        if (w_sat[LAST] && w_ovf) begin
            w_fin = w_sum[LAST][WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                         : {1'b1, {(WIDTH-1){1'b0}}};
        end
`endif
    end

    // Status flags registered alongside the final sum; carry reflects the raw add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_co   <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else if (w_adv) begin
            r_co   <= w_seg_co[LAST];
            r_ovf  <= w_ovf;
            r_zero <= (w_fin == '0);
            r_neg  <= w_fin[WIDTH-1];
        end
    end

    assign out_valid = r_vld[LAST];
    assign out_sum   = r_sum[LAST];
    assign out_co    = r_co;
    assign out_ovf   = r_ovf;
    assign out_zero  = r_zero;
    assign out_neg   = r_neg;

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe: directed corner cases, back-pressure,
// reset mid-flight and a randomized stream against an arithmetic reference model.
// Define ADDSUB_SAT_EN on both bench and RTL to exercise saturation.
module tb_addsub_pipe;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  in_a = '0;
    logic [WIDTH-1:0]  in_b = '0;
    logic              in_sub = 1'b0;
    logic              in_sat = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WIDTH-1:0]  out_sum;
    logic              out_co;
    logic              out_ovf;
    logic              out_zero;
    logic              out_neg;

    int                errs = 0;
    int                checks = 0;
    logic [35:0]       exp_q[$];
    logic              hold_pend = 1'b0;
    logic [35:0]       held = '0;

    addsub_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_sat    (in_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_co    (out_co),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero),
        .out_neg   (out_neg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: signed/unsigned arithmetic on wide integers -> {sum, co, ovf, zero, neg}
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub, input logic sat);
        longint sa, sb, tr, ua, ub;
        logic [31:0] s;
        logic co, ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        tr  = sub ? (sa - sb) : (sa + sb);
        ovf = (tr > 64'sd2147483647) || (tr < -64'sd2147483648);
        s   = tr[31:0];
        co  = sub ? (ua >= ub) : ((ua + ub) > 64'sd4294967295);
`ifdef ADDSUB_SAT_EN
        if (sat && ovf) s = (tr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`else
        if (sat) s = s;
`endif
        return {s, co, ovf, (s == 32'd0), s[31]};
    endfunction

    // One cycle: drive at negedge, track handshakes and check output beats.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic sat, input logic ordy, output logic acc);
        logic [35:0] bundle;
        @(negedge clk);
        bundle = {out_sum, out_co, out_ovf, out_zero, out_neg};
        if (hold_pend) chk("hold_stable", {out_valid, bundle}, {1'b1, held});
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        in_sat    = sat;
        out_ready = ordy;
        #1;
        chk("in_ready_rule", in_ready, !out_valid || out_ready);
        acc = v && in_ready;
        if (acc) exp_q.push_back(model(a, b, sub, sat));
        if (out_valid && out_ready) begin
            chk("beat_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("result", bundle, exp_q.pop_front());
        end
        hold_pend = out_valid && !out_ready;
        held      = bundle;
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        step(1'b0, '0, '0, 1'b0, 1'b0, ordy, acc);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            idle(1'b1);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // Offer one beat until accepted (bounded), with out_ready held high.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic sat);
        logic acc = 1'b0;
        int n = 0;
        while (!acc && n < 50) begin
            step(1'b1, a, b, sub, sat, 1'b1, acc);
            n++;
        end
        chk("send_accepted", acc, 1);
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 6))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0000;
            4: return 32'h0000_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic acc;
        int   n;
        int   sent;

        // Reset held with a beat offered: nothing comes out, everything zero
        in_valid  = 1'b1;
        in_a      = 32'h1234_5678;
        in_b      = 32'h1111_1111;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_flags", {out_co, out_ovf, out_zero, out_neg}, 0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Latency: carry crosses a segment boundary
        send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        n = 0;
        do begin
            idle(1'b1);
            n++;
        end while (!out_valid && n < 20);
        chk("latency", n, STAGES);
        chk("add_seg_carry", {out_sum, out_co, out_ovf}, {32'h0001_0000, 1'b0, 1'b0});
        drain();

        // Directed subtract / overflow corners
        send(32'd5, 32'd7, 1'b1, 1'b0);
        send(32'd7, 32'd7, 1'b1, 1'b0);
        send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1);
        send(32'h8000_0000, 32'd1, 1'b1, 1'b1);
        send(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        drain();

        // Full throughput: one acceptance per cycle with out_ready high
        sent = 0;
        n    = 0;
        while (sent < 16 && n < 40) begin
            step(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b1, acc);
            if (acc) sent++;
            n++;
        end
        chk("throughput_cycles", n, 16);
        drain();

        // Back-pressure: 8 beats, consumer stalls for three cycles mid-stream
        sent = 0;
        n    = 0;
        while (sent < 8 && n < 60) begin
            step(1'b1, rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'b0,
                 !(n >= 4 && n < 7), acc);
            if (acc) sent++;
            n++;
        end
        chk("bp_all_sent", sent, 8);
        drain();

        // Reset mid-flight: fill the pipe with the consumer stalled
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0, acc);
        idle(1'b0);
        chk("pre_rst_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_sum", out_sum, 0);
        exp_q.delete();
        hold_pend = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            idle(1'b1);
            chk("no_stale_beat", out_valid, 0);
        end

        // Randomized stream with random stalls
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, rand_op(), rand_op(),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0, acc);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
